router_input_buffer: RTL and testbench
======================================

# router_input_buffer

Per-port receive stage of the mesh router: it is the downstream end of the link driven by a neighbour's crossbar output register (`data_out` / `data_valid` / `full`). Each accepted flit is stored in a DEPTH-entry FIFO together with a precomputed XY route label. The head flit and its label are presented to the local switch allocator, and the entry is dequeued when the allocator returns `ready`. One instance sits on each of the L/N/E/S/W inputs.

## Interface
- DEPTH, 8, FIFO entries (power of two)
- WIDTH, 3, pointer width, log2(DEPTH)
- DATASIZE, 40, flit width: src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0]
- LOCAL_X, 0, this router's column (0-3)
- LOCAL_Y, 0, this router's row (0-3)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream flit valid (upstream `data_valid`)
- in_data  in  DATASIZE  upstream flit (upstream `data_out`)
- full  out  1  back-pressure to upstream; while high, upstream holds its flit
- ready  in  1  allocator ready for this port
- head_data  out  DATASIZE  flit at FIFO head
- head_label  out  4  route of head flit: {W,N,E,S} one-hot, 0000 = local, 1111 = empty/invalid
- count  out  WIDTH+1  occupancy, 0..DEPTH

## Operation
- Storage: DEPTH x (DATASIZE+4) array holding flit plus label; wr_ptr and rd_ptr are WIDTH bits and wrap naturally; count is a WIDTH+1-bit register.
- Route computation happens at write time, from in_data:
  - dst_x = dst[1:0], dst_y = dst[3:2]
  - dst_x < LOCAL_X -> 1000 (W)
  - dst_x > LOCAL_X -> 0010 (E)
  - else dst_y < LOCAL_Y -> 0100 (N)
  - else dst_y > LOCAL_Y -> 0001 (S)
  - else 0000 (local)
- push = in_valid & ~full. On push, {label, in_data} is written at wr_ptr and wr_ptr increments.
- pop = ready & (count != 0). On pop, rd_ptr increments. `ready` while empty is ignored; the allocator drives ready=1 for an invalid label.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- full = (count == DEPTH). It is a function of registered state only: no same-cycle pop bypass.
- Outputs when count != 0: head_data = stored flit at rd_ptr, head_label = stored label.
- Outputs when count == 0: head_data = 0, head_label = 1111.
- Flits are never dropped. in_valid while full is legal: the upstream register holds its flit and it is accepted at the first edge where full is low.
- Flits are delivered in strict FIFO order; contents are not modified.

## Timing
- Reset (async assert): wr_ptr = rd_ptr = 0, count = 0, full = 0, head_data = 0, head_label = 1111. The array itself is not reset. Reset mid-operation discards all stored flits immediately; there is no partial state after deassertion.
- Push latency: a flit written at edge k appears on head_data/head_label after edge k if the FIFO was empty. Head outputs are combinational from registered state.
- Pop: the head advances after the edge where pop is true. Back-to-back pops sustain 1 flit/cycle.
- Empty plus simultaneous in_valid and ready: only the push occurs; the flit is visible the next cycle and can be popped no earlier than that cycle.
- Full: full goes high the cycle after the DEPTH-th push. A pop at count == DEPTH drops count to DEPTH-1, and full falls after that edge; the held upstream flit is written at the following edge.
- Simultaneous push and pop at 0 < count < DEPTH: count is unchanged and both pointers advance.
- Throughput: 1 flit/cycle in and out concurrently when not full or empty.

## Test plan
- Reset: hold rst_n low mid-traffic with count = 5 -> count = 0, full = 0, head_label = 1111, head_data = 0 immediately; after release, the first new flit is the head.
- Routing, LOCAL_X = 1, LOCAL_Y = 1, ready = 0: push dst 4, 6, 1, 13, 5 -> popped in order with head_label 1000, 0010, 0100, 0001, 0000.
- Fill: ready = 0, push 8 flits -> full = 1 after the 8th edge, count = 8. Hold in_valid with flit 0xAA for 3 cycles -> not written. Assert ready one cycle -> count 7, full drops, then 0xAA is written and count returns to 8.
- Concurrent: count = 3, in_valid = 1 and ready = 1 for 10 cycles -> count stays 3, output order matches input order.
- Wrap-around: stream 20 flits with random ready (50%) and random in_valid -> every flit received once, in order, data bit-exact; count never exceeds 8.
- Empty edge: count = 0, ready = 1, push one flit -> no pop that cycle; head valid next cycle, popped then; count returns to 0 and head_label = 1111.

Source files
------------

// File: rtl/router_input_buffer.sv
// rtl/router_input_buffer.sv - per-port receive FIFO of the mesh router with write-time XY route labels
//
// Purpose:
//   Receives flits from a neighbour's crossbar output register. Each flit is stored
//   with a 4-bit XY route label that is computed when the flit is written. The head
//   flit and its label go to the local switch allocator. The head entry is dequeued
//   when the allocator asserts ready.
//
// Ports:
//   clk         in   1           clock
//   rst_n       in   1           asynchronous active-low reset
//   in_valid    in   1           upstream flit valid
//   in_data     in   DATASIZE    upstream flit {src, dst, timestamp, data, type}
//   full        out  1           back-pressure; upstream holds its flit while high
//   ready       in   1           allocator ready for this port
//   head_data   out  DATASIZE    flit at FIFO head, 0 when empty
//   head_label  out  4           {W,N,E,S} one-hot, 0000 local, 1111 empty
//   count       out  WIDTH+1     occupancy 0..DEPTH

module router_input_buffer #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int LOCAL_X  = 0,
    parameter int LOCAL_Y  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATASIZE-1:0] in_data,
    output logic                full,
    input  logic                ready,
    output logic [DATASIZE-1:0] head_data,
    output logic [3:0]          head_label,
    output logic [WIDTH:0]      count
);

    localparam logic [1:0]     LX          = 2'(LOCAL_X);
    localparam logic [1:0]     LY          = 2'(LOCAL_Y);
    localparam logic [WIDTH:0] DEPTH_CNT   = (WIDTH+1)'(DEPTH);
    localparam logic [3:0]     LABEL_W     = 4'b1000;
    localparam logic [3:0]     LABEL_N     = 4'b0100;
    localparam logic [3:0]     LABEL_E     = 4'b0010;
    localparam logic [3:0]     LABEL_S     = 4'b0001;
    localparam logic [3:0]     LABEL_LOCAL = 4'b0000;
    localparam logic [3:0]     LABEL_EMPTY = 4'b1111;

    // Each entry holds {label, flit}.
    logic [DATASIZE+3:0] mem [DEPTH];

    logic [WIDTH-1:0]    wr_ptr;
    logic [WIDTH-1:0]    rd_ptr;
    logic [WIDTH:0]      count_q;
    logic                push;
    logic                pop;
    logic                not_empty;
    logic [1:0]          dst_x;
    logic [1:0]          dst_y;
    logic [3:0]          in_label;
    logic [DATASIZE+3:0] head_entry;

    // dst occupies flit bits [35:32]; the column is the low pair and the row is the high pair.
    assign dst_x = in_data[33:32];
    assign dst_y = in_data[35:34];

    // XY routing: X is resolved completely before Y.
    always_comb begin
        in_label = LABEL_LOCAL;
        if (dst_x < LX) begin
            in_label = LABEL_W;
        end else if (dst_x > LX) begin
            in_label = LABEL_E;
        end else if (dst_y < LY) begin
            in_label = LABEL_N;
        end else if (dst_y > LY) begin
            in_label = LABEL_S;
        end
    end

    // full depends only on registered count. A pop in the same cycle does not free a
    // slot for the waiting upstream flit. That flit is written one edge later.
    assign not_empty = (count_q != '0);
    assign full      = (count_q == DEPTH_CNT);
    assign push      = in_valid & ~full;
    assign pop       = ready & not_empty;

    // Storage is not reset. Entries are only visible through count_q, so stale
    // contents left after a reset never reach the head outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_label, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (WIDTH+1)'(1);
                2'b01:   count_q <= count_q - (WIDTH+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The head is read combinationally from registered state. A flit written at an
    // edge into an empty FIFO is therefore visible right after that edge, and it
    // cannot be popped in the cycle it was pushed.
    assign head_entry = mem[rd_ptr];

    always_comb begin
        head_data  = '0;
        head_label = LABEL_EMPTY;
        if (not_empty) begin
            head_data  = head_entry[DATASIZE-1:0];
            head_label = head_entry[DATASIZE+3:DATASIZE];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_router_input_buffer.sv
// tb/tb_router_input_buffer.sv - scoreboard testbench for router_input_buffer
module tb_router_input_buffer;

    localparam int DEPTH    = 8;
    localparam int WIDTH    = 3;
    localparam int DATASIZE = 40;
    localparam int LX       = 1;
    localparam int LY       = 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [DATASIZE-1:0] in_data = '0;
    logic                full;
    logic                ready = 1'b0;
    logic [DATASIZE-1:0] head_data;
    logic [3:0]          head_label;
    logic [WIDTH:0]      count;

    router_input_buffer #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DATASIZE),
        .LOCAL_X(LX), .LOCAL_Y(LY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .full(full), .ready(ready), .head_data(head_data),
        .head_label(head_label), .count(count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pushed_n = 0;
    int popped_n = 0;
    int sz;
    logic [DATASIZE-1:0] exp_q[$];

    int         dsts[5] = '{4, 6, 1, 13, 5};
    logic [3:0] labs[5] = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b0000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Label computed from the dst field with plain arithmetic.
    function automatic logic [3:0] ref_label(input logic [DATASIZE-1:0] f);
        int dst;
        int dx;
        int dy;
        dst = int'(f[35:32]);
        dx = dst % 4;
        dy = dst / 4;
        if (dx < LX) return 4'b1000;
        if (dx > LX) return 4'b0010;
        if (dy < LY) return 4'b0100;
        if (dy > LY) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [DATASIZE-1:0] rand_flit();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DATASIZE-1:0];
    endfunction

    // Reference model: the FIFO is an unbounded queue capped at DEPTH by the acceptance rule.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            sz = exp_q.size();
            if (ready && sz != 0) begin
                void'(exp_q.pop_front());
                popped_n++;
            end
            if (in_valid && sz != DEPTH) begin
                exp_q.push_back(in_data);
                pushed_n++;
            end
        end
    end

    // Monitor: compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count", 64'(count), 64'(exp_q.size()));
            check("full", 64'(full), 64'(exp_q.size() == DEPTH));
            check("count_bound", 64'(count <= DEPTH), 64'(1));
            if (exp_q.size() != 0) begin
                check("head_data", 64'(head_data), 64'(exp_q[0]));
                check("head_label", 64'(head_label), 64'(ref_label(exp_q[0])));
            end else begin
                check("empty_data", 64'(head_data), 64'(0));
                check("empty_label", 64'(head_label), 64'(4'b1111));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [DATASIZE-1:0] f;
        logic [DATASIZE-1:0] first;
        logic                pending;
        logic                acc;
        int                  sent;

        // Reset state
        step();
        step();
        check("rst_count", 64'(count), 64'(0));
        check("rst_full", 64'(full), 64'(0));
        check("rst_label", 64'(head_label), 64'(4'b1111));
        check("rst_data", 64'(head_data), 64'(0));
        rst_n = 1'b1;
        step();

        // Routing: all five labels, popped in order
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            f = rand_flit();
            f[35:32] = 4'(dsts[i]);
            in_data = f;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("route_label", 64'(head_label), 64'(labs[i]));
            step();
        end
        ready = 1'b0;
        check("route_drained", 64'(count), 64'(0));

        // Fill, hold a flit while full, release one slot
        for (int i = 0; i < DEPTH; i++) begin
            in_data = rand_flit();
            if (i == 0) first = in_data;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("fill_full", 64'(full), 64'(1));
        check("fill_count", 64'(count), 64'(8));
        in_data = 40'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("hold_count", 64'(count), 64'(8));
        check("hold_head", 64'(head_data), 64'(first));
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("pop_full_count", 64'(count), 64'(7));
        check("pop_full_flag", 64'(full), 64'(0));
        step();
        in_valid = 1'b0;
        check("held_written", 64'(count), 64'(8));
        check("held_full", 64'(full), 64'(1));
        ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("held_last", 64'(head_data), 64'(40'hAA));
        step();
        ready = 1'b0;
        check("fill_drained", 64'(count), 64'(0));

        // Concurrent push and pop at count 3
        for (int i = 0; i < 3; i++) begin
            in_data = rand_flit();
            in_valid = 1'b1;
            step();
        end
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = rand_flit();
            step();
            check("conc_count", 64'(count), 64'(3));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ready = 1'b0;
        check("conc_drained", 64'(count), 64'(0));

        // Empty edge: push and ready together while empty
        f = rand_flit();
        in_data = f;
        in_valid = 1'b1;
        ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("empty_edge_count", 64'(count), 64'(1));
        check("empty_edge_head", 64'(head_data), 64'(f));
        step();
        ready = 1'b0;
        check("empty_edge_pop", 64'(count), 64'(0));
        check("empty_edge_label", 64'(head_label), 64'(4'b1111));

        // Wrap-around stream with random valid and ready
        sent = 0;
        pending = 1'b0;
        for (int cyc = 0; cyc < 2000 && sent < 20; cyc++) begin
            if (!pending && $urandom_range(1, 0) == 1) begin
                in_data = rand_flit();
                pending = 1'b1;
            end
            in_valid = pending;
            ready = 1'($urandom_range(1, 0));
            acc = pending && !full;
            step();
            if (acc) begin
                pending = 1'b0;
                sent++;
            end
        end
        in_valid = 1'b0;
        check("stream_sent", 64'(sent), 64'(20));
        ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        ready = 1'b0;
        check("stream_drained", 64'(count), 64'(0));
        check("pop_equals_push", 64'(popped_n), 64'(pushed_n));

        // Reset mid-traffic at count 5
        for (int i = 0; i < 5; i++) begin
            in_data = rand_flit();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'(5));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 64'(count), 64'(0));
        check("mid_rst_full", 64'(full), 64'(0));
        check("mid_rst_label", 64'(head_label), 64'(4'b1111));
        check("mid_rst_data", 64'(head_data), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        f = rand_flit();
        in_data = f;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_count", 64'(count), 64'(1));
        check("post_rst_head", 64'(head_data), 64'(f));
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("post_rst_drained", 64'(count), 64'(0));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
